// File: rtl/axi_ram_pkg.sv
// Shared definitions for the AXI RAM read/write controllers: response codes
// and the controller FSM state encoding.
package axi_ram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } rd_state_t;

  // Byte-lane shift between AXI byte addresses and RAM word addresses.
  function automatic int unsigned byte_shift(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_ram_rd_buf.sv
// Two-entry FIFO holding returned read beats (data + response) while the
// AXI R channel is stalled.
module axi_ram_rd_buf #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [1:0]            push_resp,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [1:0]            head_resp,
  output logic [1:0]            occupancy
);

  logic [DATA_WIDTH-1:0] data_mem [2];
  logic [1:0]            resp_mem [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [1:0]            count_reg;
  logic                  do_pop;

  // Popping an empty buffer is ignored so the count can never underflow.
  assign do_pop = pop && (count_reg != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        data_mem[i] <= '0;
        resp_mem[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        data_mem[wr_ptr_reg] <= push_data;
        resp_mem[wr_ptr_reg] <= push_resp;
        wr_ptr_reg           <= ~wr_ptr_reg;
      end
      if (do_pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_reg + {1'b0, push} - {1'b0, do_pop};
    end
  end

  assign head_data = data_mem[rd_ptr_reg];
  assign head_resp = resp_mem[rd_ptr_reg];
  assign occupancy = count_reg;

endmodule

// File: rtl/axi_ram_read_ctrl.sv
// AXI4 INCR read-burst slave driving a synchronous RAM read port.
// Optional AR range checking is enabled by defining AXI_RAM_RD_RANGE_CHECK_EN.
module axi_ram_read_ctrl
  import axi_ram_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int MEM_DEPTH      = 256,
  parameter int ADDR_WIDTH     = $clog2(MEM_DEPTH),
  parameter int AXI_ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [DATA_WIDTH-1:0]     s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [ADDR_WIDTH-1:0]     ram_read_addr,
  output logic                      ram_read_enable,
  input  logic [DATA_WIDTH-1:0]     ram_read_data
);

  localparam int BSH = byte_shift(DATA_WIDTH);

  rd_state_t             state_reg, state_next;
  logic                  arready_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [8:0]            issue_cnt_reg;
  logic [8:0]            ret_cnt_reg;
  logic                  inflight_reg;
  logic                  err_reg;

  logic [ADDR_WIDTH-1:0] ar_word;
  logic                  ar_err;
  logic                  ar_fire;
  logic                  issue;
  logic                  r_fire;
  logic                  last_fire;
  logic                  buf_empty;
  logic                  buf_push;
  logic                  buf_pop;
  logic [1:0]            buf_occ;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [1:0]            buf_resp;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [1:0]            beat_resp;
  logic                  unused_addr_bits;

  assign ar_word          = s_axi_araddr[ADDR_WIDTH+BSH-1:BSH];
  assign unused_addr_bits = ^s_axi_araddr;

`ifdef AXI_RAM_RD_RANGE_CHECK_EN
  assign ar_err = (32'(ar_word) + 32'(s_axi_arlen) > 32'(MEM_DEPTH - 1)) ||
                  (|s_axi_araddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH+BSH]);
`else
  assign ar_err = 1'b0;
`endif

  assign ar_fire   = arready_reg && s_axi_arvalid;
  assign buf_empty = (buf_occ == 2'd0);

  // Buffered beats plus the read still in the RAM pipeline may never exceed 2.
  assign issue = (state_reg == ST_BURST) && (issue_cnt_reg != 9'd0) &&
                 (({1'b0, buf_occ} + {2'b00, inflight_reg}) < 3'd2);

  // Flagged bursts keep the same slot timing but never touch the RAM.
  assign beat_data = err_reg ? '0 : ram_read_data;
  assign beat_resp = err_reg ? RESP_SLVERR : RESP_OKAY;

  // An empty buffer lets the beat leaving the RAM go straight to R.
  assign s_axi_rvalid = !buf_empty || inflight_reg;
  assign s_axi_rdata  = (buf_empty && inflight_reg) ? beat_data : buf_data;
  assign s_axi_rresp  = (buf_empty && inflight_reg) ? beat_resp : buf_resp;
  assign s_axi_rlast  = s_axi_rvalid && (ret_cnt_reg == 9'd1);

  assign r_fire    = s_axi_rvalid && s_axi_rready;
  assign last_fire = r_fire && (ret_cnt_reg == 9'd1);
  assign buf_pop   = r_fire && !buf_empty;
  assign buf_push  = inflight_reg && !(buf_empty && r_fire);

  assign s_axi_arready   = arready_reg;
  assign ram_read_enable = issue && !err_reg;
  assign ram_read_addr   = addr_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (ar_fire)   state_next = ST_BURST;
      ST_BURST: if (last_fire) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      arready_reg   <= 1'b0;
      addr_reg      <= '0;
      issue_cnt_reg <= 9'd0;
      ret_cnt_reg   <= 9'd0;
      inflight_reg  <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg    <= state_next;
      arready_reg  <= (state_next == ST_IDLE);
      inflight_reg <= issue;
      if (ar_fire) begin
        addr_reg      <= ar_word;
        issue_cnt_reg <= {1'b0, s_axi_arlen} + 9'd1;
        ret_cnt_reg   <= {1'b0, s_axi_arlen} + 9'd1;
        err_reg       <= ar_err;
      end else begin
        if (issue) begin
          addr_reg      <= (addr_reg == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : addr_reg + 1'b1;
          issue_cnt_reg <= issue_cnt_reg - 9'd1;
        end
        if (r_fire) begin
          ret_cnt_reg <= ret_cnt_reg - 9'd1;
        end
      end
    end
  end

  axi_ram_rd_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (beat_data),
    .push_resp (beat_resp),
    .pop       (buf_pop),
    .head_data (buf_data),
    .head_resp (buf_resp),
    .occupancy (buf_occ)
  );

endmodule

// File: tb/tb_axi_ram_read_ctrl.sv
// Self-checking bench for axi_ram_read_ctrl: table of directed bursts plus
// hand-written reset sequences. Honours AXI_RAM_RD_RANGE_CHECK_EN.
module tb_axi_ram_read_ctrl;

  localparam int DW    = 64;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
  localparam int AXW   = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [AXW-1:0] s_axi_araddr = '0;
  logic [7:0]     s_axi_arlen = '0;
  logic           s_axi_arvalid = 1'b0;
  logic           s_axi_arready;
  logic [DW-1:0]  s_axi_rdata;
  logic [1:0]     s_axi_rresp;
  logic           s_axi_rlast;
  logic           s_axi_rvalid;
  logic           s_axi_rready = 1'b0;
  logic [AW-1:0]  ram_read_addr;
  logic           ram_read_enable;
  logic [DW-1:0]  ram_read_data;

  always #5 clk = ~clk;

  axi_ram_read_ctrl #(
    .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .AXI_ADDR_WIDTH(AXW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_axi_araddr    (s_axi_araddr),
    .s_axi_arlen     (s_axi_arlen),
    .s_axi_arvalid   (s_axi_arvalid),
    .s_axi_arready   (s_axi_arready),
    .s_axi_rdata     (s_axi_rdata),
    .s_axi_rresp     (s_axi_rresp),
    .s_axi_rlast     (s_axi_rlast),
    .s_axi_rvalid    (s_axi_rvalid),
    .s_axi_rready    (s_axi_rready),
    .ram_read_addr   (ram_read_addr),
    .ram_read_enable (ram_read_enable),
    .ram_read_data   (ram_read_data)
  );

  // Synchronous-read RAM model, word k holds k.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q = '0;
  always @(posedge clk) if (ram_read_enable) ram_q <= mem[ram_read_addr];
  assign ram_read_data = ram_q;

  // Outstanding-read monitor: OKAY beats returned vs RAM reads issued.
  int issued_cnt = 0;
  int recvd_cnt  = 0;
  int viol_cnt   = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      issued_cnt <= 0;
      recvd_cnt  <= 0;
    end else begin
      if (ram_read_enable) begin
        issued_cnt <= issued_cnt + 1;
        if (issued_cnt - recvd_cnt >= 2) viol_cnt <= viol_cnt + 1;
      end
      if (s_axi_rvalid && s_axi_rready && s_axi_rresp == 2'b00) recvd_cnt <= recvd_cnt + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  pat;        // rready pattern, bit i used on cycle i
    int          pat_len;
    logic [63:0] first_word; // expected data of beat 0 when not flagged
    bit          err_chk;    // burst is flagged when range checking is built in
  } vec_t;

  vec_t vecs[9];

  task automatic check_reset_outputs(input string tag);
    check({tag, " arready"}, 64'(s_axi_arready), 64'd0);
    check({tag, " rvalid"}, 64'(s_axi_rvalid), 64'd0);
    check({tag, " rlast"}, 64'(s_axi_rlast), 64'd0);
    check({tag, " rresp"}, 64'(s_axi_rresp), 64'd0);
    check({tag, " rdata"}, s_axi_rdata, 64'd0);
    check({tag, " ram_en"}, 64'(ram_read_enable), 64'd0);
    check({tag, " ram_addr"}, 64'(ram_read_addr), 64'd0);
  endtask

  task automatic run_burst(input vec_t v);
    logic        exp_err;
    logic [63:0] exp_d;
    int first_idx, beats, idx, last_idx, arr_bad, en_before, viol_before;
`ifdef AXI_RAM_RD_RANGE_CHECK_EN
    exp_err = v.err_chk;
`else
    exp_err = 1'b0;
`endif
    en_before   = issued_cnt;
    viol_before = viol_cnt;
    s_axi_araddr  = v.addr;
    s_axi_arlen   = v.len;
    s_axi_arvalid = 1'b1;
    for (int k = 0; k < 20 && !s_axi_arready; k++) begin
      @(posedge clk); #1;
    end
    check({v.tag, " ar_handshake"}, 64'(s_axi_arready), 64'd1);
    if (!s_axi_arready) begin
      s_axi_arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    s_axi_araddr  = '0;
    s_axi_arlen   = '0;
    first_idx = -1; beats = 0; arr_bad = 0; last_idx = -1; idx = 1;
    while (beats <= int'(v.len) && idx < 1200) begin
      s_axi_rready = v.pat[(idx - 1) % v.pat_len];
      if (s_axi_rvalid && first_idx < 0) first_idx = idx;
      if (s_axi_arready) arr_bad++;
      if (s_axi_rvalid && s_axi_rready) begin
        exp_d = exp_err ? 64'd0 : ((v.first_word + 64'(beats)) & 64'hFF);
        check($sformatf("%s data%0d", v.tag, beats), s_axi_rdata, exp_d);
        check($sformatf("%s resp%0d", v.tag, beats), 64'(s_axi_rresp), exp_err ? 64'd2 : 64'd0);
        check($sformatf("%s rlast%0d", v.tag, beats), 64'(s_axi_rlast),
              64'(beats == int'(v.len)));
        last_idx = idx;
        beats++;
      end
      @(posedge clk); #1;
      idx++;
    end
    s_axi_rready = 1'b0;
    check({v.tag, " beat_count"}, 64'(beats), 64'(int'(v.len) + 1));
    check({v.tag, " first_latency"}, 64'(first_idx), 64'd2);
    if (v.pat_len == 1) check({v.tag, " last_cycle"}, 64'(last_idx), 64'(int'(v.len) + 2));
    check({v.tag, " arready_low_in_burst"}, 64'(arr_bad), 64'd0);
    check({v.tag, " arready_after"}, 64'(s_axi_arready), 64'd1);
    check({v.tag, " no_extra_beat"}, 64'(s_axi_rvalid), 64'd0);
    check({v.tag, " issue_limit"}, 64'(viol_cnt - viol_before), 64'd0);
    check({v.tag, " ram_reads"}, 64'(issued_cnt - en_before),
          exp_err ? 64'd0 : 64'(int'(v.len) + 1));
    $display("burst %s addr=%0h len=%0d beats=%0d first=%0d err=%0d",
             v.tag, v.addr, v.len, beats, first_idx, exp_err);
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mem[k] = 64'(k);
    vecs[0] = '{"b4_full",    32'h40,      8'd3,   8'h01, 1, 64'd8,   1'b0};
    vecs[1] = '{"b4_pattern", 32'h40,      8'd3,   8'h69, 7, 64'd8,   1'b0};
    vecs[2] = '{"b4_toggle",  32'h40,      8'd3,   8'h01, 2, 64'd8,   1'b0};
    vecs[3] = '{"wrap",       32'h7F8,     8'd1,   8'h01, 1, 64'd255, 1'b1};
    vecs[4] = '{"single",     32'h10,      8'd0,   8'h01, 1, 64'd2,   1'b0};
    vecs[5] = '{"b256",       32'h0,       8'd255, 8'h01, 1, 64'd0,   1'b0};
    vecs[6] = '{"b2b_single", 32'h0,       8'd0,   8'h01, 1, 64'd0,   1'b0};
    vecs[7] = '{"upper_bits", 32'h0001_0048, 8'd1, 8'h03, 2, 64'd9,   1'b1};
    vecs[8] = '{"after_rst",  32'h0,       8'd1,   8'h01, 1, 64'd0,   1'b0};

    // Power-on reset.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    check("por arready_before_edge", 64'(s_axi_arready), 64'd0);
    @(posedge clk); #1;
    check("por arready_first_edge", 64'(s_axi_arready), 64'd1);

    for (int i = 0; i < 8; i++) run_burst(vecs[i]);

    // Reset asserted three cycles into an 8-beat burst.
    s_axi_araddr  = 32'h0;
    s_axi_arlen   = 8'd7;
    s_axi_arvalid = 1'b1;
    for (int k = 0; k < 20 && !s_axi_arready; k++) begin
      @(posedge clk); #1;
    end
    check("abort ar_handshake", 64'(s_axi_arready), 64'd1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
    s_axi_arlen   = '0;
    s_axi_rready  = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("abort mid_burst_rvalid", 64'(s_axi_rvalid), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_now");
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("abort_held");
    s_axi_rready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort arready_back", 64'(s_axi_arready), 64'd1);
    check("abort rvalid_clear", 64'(s_axi_rvalid), 64'd0);

    run_burst(vecs[8]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
